// File: rtl/itcm_loader_if.sv
// Load-stream bundle between the boot source and the ITCM loader.
// The master drives words; the slave answers with ld_ready.
interface itcm_loader_if #(
    parameter int DW = 32
) ();
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/itcm_loader.sv
// Streams a boot image into ITCM and holds the core in reset until
// the image is written and a fixed settle delay has elapsed.
module itcm_loader #(
    parameter int DW       = 32,
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH),
    parameter int HOLD_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    itcm_loader_if.slave  ld,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          core_rst_n,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] csum,
    output logic [AW:0]   wcount
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } st_t;

    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);
    localparam logic [7:0]  HOLD_END  = 8'(HOLD_CYC - 1);

    st_t        st;
    st_t        nxt;
    logic [7:0] hcnt;
    logic       acc;
    logic       at_end;
    logic       hold_done;

    assign acc       = ld.ld_valid && ld.ld_ready;
    assign at_end    = (wcount == LAST_ADDR);
    assign hold_done = (hcnt == HOLD_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= LOAD;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt = st;
        unique case (st)
            LOAD: begin
                if (acc && ld.ld_last) begin
                    nxt = HOLD;
                end else if (acc && at_end) begin
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (acc && ld.ld_last) begin
                    nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    nxt = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    nxt = LOAD;
                end
            end
            default: nxt = LOAD;
        endcase
    end

    always_comb begin
        ld.ld_ready = (st == LOAD) || (st == DRAIN);
        core_rst_n  = (st == RUN);
        done        = (st == RUN);
    end

    // The last word that fits still lands in memory; only the excess drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wcount    <= '0;
            csum      <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (st == LOAD && acc) begin
                mem_we    <= 1'b1;
                mem_addr  <= wcount[AW-1:0];
                mem_wdata <= ld.ld_data;
                wcount    <= wcount + 1'b1;
                csum      <= csum + ld.ld_data;
                if (!ld.ld_last && at_end) begin
                    err <= 1'b1;
                end
            end
            if (st == RUN && reload) begin
                wcount <= '0;
                csum   <= '0;
                err    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
        end else if (st == HOLD && !hold_done) begin
            hcnt <= hcnt + 8'd1;
        end else begin
            hcnt <= '0;
        end
    end

endmodule

// File: tb/tb_itcm_loader.sv
// Self-checking bench for itcm_loader: vector table, write scoreboard
// and directed sequences for overflow, reload and mid-load reset.
module tb_itcm_loader;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int HOLD  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reload = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          err;
    logic [DW-1:0] csum;
    logic [AW:0]   wcount;

    always #5 clk = ~clk;

    itcm_loader_if #(.DW(DW)) ldif ();

    itcm_loader #(
        .DW(DW),
        .DEPTH(DEPTH),
        .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ld(ldif),
        .reload(reload),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_rst_n(core_rst_n),
        .done(done),
        .err(err),
        .csum(csum),
        .wcount(wcount)
    );

    typedef struct packed {
        logic [AW:0]   a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          rdy;
    } vec_t;

    wr_t         sbq[$];
    vec_t        tv[10];
    int          tot = 0;
    int          bad = 0;
    int          mmode;
    logic [AW:0] mcnt;
    logic [DW-1:0] msum;
    logic        merr;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        mmode = 0;
        mcnt  = '0;
        msum  = '0;
        merr  = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic l);
        @(negedge clk);
        ldif.ld_valid = v;
        ldif.ld_data  = d;
        ldif.ld_last  = l;
        chk("ld_ready", DW'(ldif.ld_ready), (mmode < 2) ? 32'd1 : 32'd0);
        if (v && ldif.ld_ready) begin
            if (mmode == 0) begin
                sbq.push_back({mcnt, d});
                msum = msum + d;
                mcnt = mcnt + 1'b1;
                if (l) begin
                    mmode = 2;
                end else if (mcnt == (AW+1)'(DEPTH)) begin
                    mmode = 1;
                    merr  = 1'b1;
                end
            end else if (mmode == 1 && l) begin
                mmode = 2;
            end
        end
    endtask

    task automatic wait_run(input int rl_at);
        @(negedge clk);
        ldif.ld_valid = 1'b0;
        ldif.ld_last  = 1'b0;
        chk("hold_core_rst_n", DW'(core_rst_n), 32'd0);
        chk("hold_ready", DW'(ldif.ld_ready), 32'd0);
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clk);
            reload = (i == rl_at);
            chk("core_rst_n", DW'(core_rst_n), (i == HOLD) ? 32'd1 : 32'd0);
            chk("done", DW'(done), (i == HOLD) ? 32'd1 : 32'd0);
        end
        reload = 1'b0;
        mmode  = 3;
    endtask

    task automatic check_result();
        chk("csum", csum, msum);
        chk("wcount", DW'(wcount), DW'(mcnt));
        chk("err", DW'(err), DW'(merr));
        chk("sb_empty", DW'(sbq.size()), 32'd0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        chk("done_before_reload", DW'(done), 32'd1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("rl_core_rst_n", DW'(core_rst_n), 32'd0);
        chk("rl_done", DW'(done), 32'd0);
        chk("rl_csum", csum, 32'd0);
        chk("rl_wcount", DW'(wcount), 32'd0);
        chk("rl_err", DW'(err), 32'd0);
        chk("rl_ready", DW'(ldif.ld_ready), 32'd1);
        model_clear();
    endtask

    initial begin
        tv[0] = '{1'b1, 32'h100137b7, 1'b0, 1'b1};
        tv[1] = '{1'b1, 32'h00000013, 1'b0, 1'b1};
        tv[2] = '{1'b1, 32'h0000006f, 1'b1, 1'b1};
        tv[3] = '{1'b1, 32'h11111111, 1'b0, 1'b1};
        tv[4] = '{1'b0, 32'hbad0bad0, 1'b0, 1'b1};
        tv[5] = '{1'b1, 32'h22222222, 1'b0, 1'b1};
        tv[6] = '{1'b0, 32'hbad1bad1, 1'b1, 1'b1};
        tv[7] = '{1'b1, 32'h33333333, 1'b0, 1'b1};
        tv[8] = '{1'b0, 32'hbad2bad2, 1'b1, 1'b1};
        tv[9] = '{1'b1, 32'h44444444, 1'b1, 1'b1};

        ldif.ld_valid = 1'b0;
        ldif.ld_data  = '0;
        ldif.ld_last  = 1'b0;
        model_clear();

        fork
            forever begin
                @(negedge clk);
                if (mem_we === 1'b1) begin
                    if (sbq.size() == 0) begin
                        tot++;
                        bad++;
                        $display("FAIL spurious_write: got addr %0d data %h want none",
                                 mem_addr, mem_wdata);
                    end else begin
                        wr_t e;
                        e = sbq.pop_front();
                        chk("wr_addr", DW'({1'b0, mem_addr}), DW'(e.a));
                        chk("wr_data", mem_wdata, e.d);
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_mem_we", DW'(mem_we), 32'd0);
        chk("rst_mem_addr", DW'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_core_rst_n", DW'(core_rst_n), 32'd0);
        chk("rst_done", DW'(done), 32'd0);
        check_result();
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            drive(tv[i].v, tv[i].d, tv[i].l);
            chk("tv_ready", DW'(ldif.ld_ready), DW'(tv[i].rdy));
        end
        wait_run(0);
        chk("boot_csum", csum, 32'h10013839);
        chk("boot_wcount", DW'(wcount), 32'd3);
        check_result();

        do_reload();
        drive(1'b1, 32'hdeadbeef, 1'b1);
        wait_run(2);
        check_result();

        do_reload();
        for (int i = 3; i < 10; i++) begin
            drive(tv[i].v, tv[i].d, tv[i].l);
            chk("tv_ready", DW'(ldif.ld_ready), DW'(tv[i].rdy));
        end
        wait_run(0);
        chk("toggle_wcount", DW'(wcount), 32'd4);
        check_result();

        do_reload();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h1000 + k, k == 9);
        end
        wait_run(0);
        chk("ovf_err", DW'(err), 32'd1);
        chk("ovf_wcount", DW'(wcount), 32'd8);
        chk("ovf_csum", csum, 32'h801c);
        check_result();

        do_reload();
        drive(1'b1, 32'haaaa0001, 1'b0);
        @(negedge clk);
        ldif.ld_data = 32'haaaa0002;
        #2;
        rst_n = 1'b0;
        ldif.ld_valid = 1'b0;
        #1;
        chk("mid_mem_we", DW'(mem_we), 32'd0);
        chk("mid_mem_addr", DW'(mem_addr), 32'd0);
        chk("mid_mem_wdata", mem_wdata, 32'd0);
        chk("mid_wcount", DW'(wcount), 32'd0);
        chk("mid_csum", csum, 32'd0);
        chk("mid_core_rst_n", DW'(core_rst_n), 32'd0);
        chk("mid_done", DW'(done), 32'd0);
        model_clear();
        check_result();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h00000055, 1'b0);
        drive(1'b1, 32'h00000066, 1'b1);
        wait_run(0);
        check_result();

        repeat (2) @(negedge clk);
        chk("final_sb_empty", DW'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/itcm_loader.md
ITCM_LOADER -- requirements
Module: itcm_loader

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning ITCM depth in words.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), meaning ITCM word-address width.
REQ-004 SHALL have parameter HOLD_CYC, default 4 (range 1..255), meaning cycles core reset stays asserted after load end.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports ld_valid, ld_data, ld_last  input  1/DW/1  load stream: word valid, word, final word.
REQ-008 SHALL have port ld_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port reload  input  1  single-cycle request to restart loading.
REQ-010 SHALL have ports mem_we, mem_addr, mem_wdata  output  1/AW/DW  registered ITCM write port.
REQ-011 SHALL have port core_rst_n  output  1  active-low reset to the CPU core.
REQ-012 SHALL have ports done, err  output  1/1  load complete; overflow occurred.
REQ-013 SHALL have port csum  output  DW  sum of written words, modulo 2^DW.
REQ-014 SHALL have port wcount  output  AW+1  number of words written to ITCM.

Function
REQ-015 SHALL implement FSM states LOAD, DRAIN, HOLD, RUN; no other reachable states.
REQ-016 SHALL assert ld_ready in LOAD and DRAIN only; a word is accepted when ld_valid && ld_ready.
REQ-017 In LOAD, each accepted word SHALL produce mem_we=1, mem_addr=wcount (pre-increment), mem_wdata=ld_data exactly one cycle later; mem_we=0 in all other cycles.
REQ-018 Each word written SHALL increment wcount by 1 and add ld_data to csum, truncated to DW bits.
REQ-019 LOAD -> HOLD when an accepted word has ld_last=1 (that word is still written).
REQ-020 LOAD -> DRAIN when the word accepted at address DEPTH-1 has ld_last=0; that word is written and err set to 1.
REQ-021 In DRAIN, accepted words SHALL be discarded (no write, no csum/wcount change); DRAIN -> HOLD on accepted ld_last=1.
REQ-022 HOLD SHALL count HOLD_CYC cycles then enter RUN; ld_ready=0 throughout.
REQ-023 core_rst_n SHALL be 0 in LOAD, DRAIN, HOLD and 1 only in RUN; done SHALL equal (state==RUN).
REQ-024 reload=1 in RUN SHALL, next cycle: enter LOAD, clear wcount, csum, err, done, and drive core_rst_n=0.
REQ-025 reload in LOAD, DRAIN or HOLD SHALL be ignored.
REQ-026 An empty load is not possible; the first accepted word always writes address 0.
REQ-027 err and csum/wcount SHALL hold their values in RUN until reload or reset.

Reset
REQ-028 On rst_n=0, asynchronously: state=LOAD, wcount=0, csum=0, err=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, HOLD counter=0.
REQ-029 Reset asserted mid-load SHALL abandon the load; after release loading restarts at address 0.
REQ-030 ld_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-031 Stream 3 words 0x100137b7, 0x00000013, 0x0000006f (last on 3rd) -> writes to addr 0,1,2 one cycle after each accept; csum=0x10013839; wcount=3; core_rst_n=1 exactly HOLD_CYC cycles after last write cycle.
REQ-032 ld_valid toggled 1/0 every cycle over 4 words -> no gaps filled, addresses strictly 0..3, no duplicate writes.
REQ-033 DEPTH=8, 10 words with last on 10th -> 8 writes, err=1, wcount=8, words 9-10 discarded, then RUN.
REQ-034 reload pulse in RUN then 1-word load -> core_rst_n falls next cycle, csum/err cleared, new word written at addr 0.
REQ-035 rst_n low during 2nd word of a load -> all outputs reset immediately; subsequent load writes from addr 0.
REQ-036 reload asserted during HOLD -> ignored; RUN entered on schedule.
